cm_sketch_feeder: RTL and testbench
===================================

CM_SKETCH_FEEDER -- requirements
Module: cm_sketch_feeder

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 22, address width on both ports.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, buffer entries; must be a power of 2 and at least 2.
REQ-003 SHALL have parameter EPOCH_LEN, default 1024, number of sketch-accepted addresses per epoch.
REQ-004 SHALL have parameter FLUSH_WAIT, default 6, idle cycles after a query pulse; must be at least 5.
REQ-005 SHALL have port clk, input, 1, clock; all logic on posedge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid, input, 1, upstream address valid.
REQ-008 SHALL have port in_addr, input, ADDR_SIZE, upstream page address.
REQ-009 SHALL have port in_ready, output, 1, buffer not full.
REQ-010 SHALL have port force_query, input, 1, single-cycle request to end the epoch early.
REQ-011 SHALL have port sk_valid, output, 1, address offered to the sketch.
REQ-012 SHALL have port sk_addr, output, ADDR_SIZE, offered address.
REQ-013 SHALL have port sk_ready, input, 1, sketch accept.
REQ-014 SHALL have port sk_query_en, output, 1, one-cycle query/flush strobe to the sketch.
REQ-015 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1, occupied entries.
REQ-016 SHALL have port epoch_cnt, output, 16, completed queries; wraps at 65535 to 0.
REQ-017 SHALL have port busy, output, 1, high when state is not IDLE or fifo_level is nonzero.

Function
REQ-018 SHALL push in_addr into the FIFO on a cycle where in_valid and in_ready are both high; in_ready = (fifo_level != FIFO_DEPTH).
REQ-019 SHALL pop the FIFO head only on a cycle where sk_valid and sk_ready are both high.
REQ-020 SHALL handle a push and a pop in the same cycle with fifo_level unchanged and order preserved.
REQ-021 SHALL use read/write pointers with one extra wrap bit, modulo FIFO_DEPTH.
REQ-022 SHALL implement FSM states IDLE, SEND, QUERY and WAIT, held in registers.
REQ-023 IDLE transitions: if query_pending, go to QUERY; else if FIFO is non-empty, go to SEND; else stay in IDLE.
REQ-024 SEND SHALL hold sk_valid=1 with sk_addr = FIFO head, stable until accepted.
REQ-025 SEND SHALL return to IDLE on the cycle after acceptance, so sk_valid is low for at least one cycle between transfers.
REQ-026 SHALL drive sk_addr to 0 whenever sk_valid is 0.
REQ-027 SHALL keep an internal sent_cnt, incremented on each sketch acceptance.
REQ-028 When an acceptance makes sent_cnt equal EPOCH_LEN, SHALL set query_pending, with sent_cnt held at that value.
REQ-029 force_query SHALL set query_pending when the state is IDLE or SEND.
REQ-030 force_query SHALL be ignored when the state is QUERY or WAIT.
REQ-031 A force_query coinciding with the threshold hit SHALL produce one query only.
REQ-032 A pending query SHALL never abort an offered address; SEND completes first.
REQ-033 QUERY SHALL last exactly 1 cycle with sk_query_en=1 and sk_valid=0.
REQ-034 On entering QUERY, SHALL clear sent_cnt and query_pending; then go to WAIT.
REQ-035 WAIT SHALL last exactly FLUSH_WAIT cycles with sk_valid=0 and sk_query_en=0, then go to IDLE.
REQ-036 SHALL increment epoch_cnt on the WAIT-to-IDLE transition.
REQ-037 SHALL keep accepting upstream pushes in every state while the FIFO is not full.
REQ-038 Per-address latency: SEND is entered 2 cycles after a push into an empty FIFO with the FSM in IDLE.

Reset
REQ-039 On rst_n low (any time, mid-transfer included), SHALL immediately set state=IDLE, both pointers=0, sent_cnt=0, query_pending=0, wait counter=0 and epoch_cnt=0.
REQ-040 The resulting output values SHALL be in_ready=1, sk_valid=0, sk_addr=0, sk_query_en=0, fifo_level=0 and busy=0.
REQ-041 FIFO contents SHALL be discarded on reset.
REQ-042 SHALL leave the FIFO storage array unreset.

Verification
REQ-043 Push 0x00ABC, sk_ready tied 1 -> one sk_valid pulse carrying 0x00ABC; fifo_level 1->0; no sk_query_en.
REQ-044 Push 9 addresses back-to-back, sk_ready=0, FIFO_DEPTH=8 -> in_ready low after the 8th; 9th held upstream; release sk_ready -> 9 addresses emitted in push order.
REQ-045 EPOCH_LEN=4, stream 6 addresses -> sk_query_en exactly 1 cycle after the 4th acceptance's IDLE; sk_valid low for 1+FLUSH_WAIT cycles; epoch_cnt=1; addresses 5-6 follow.
REQ-046 Assert force_query during SEND with sk_ready=0 for 3 cycles -> address delivered first, then one query; a second force_query during WAIT is ignored; epoch_cnt=1.
REQ-047 Simultaneous push and pop at fifo_level=3 -> level stays 3; pointer wrap after 20 transfers preserves order.
REQ-048 Drop rst_n while in SEND with 5 entries -> all outputs take reset values asynchronously; after release, no stale address is emitted.

Source files
------------

// File: rtl/cm_sketch_feeder.sv
// cm_sketch_feeder
//   Buffers upstream page addresses in a small FIFO and offers them one at a
//   time to a count-min sketch. After EPOCH_LEN accepted addresses (or an
//   early force_query) it issues a single-cycle query/flush strobe. It then
//   stays quiet for FLUSH_WAIT cycles so the sketch can drain before the next
//   epoch starts. Upstream pushes are accepted in every state while the
//   buffer has room.
//
// Ports
//   clk, rst_n         clock (posedge) and asynchronous active-low reset
//   in_valid/in_addr   upstream address offer; in_ready = buffer not full
//   force_query        single-cycle request to end the current epoch early
//   sk_valid/sk_addr   address offered to the sketch (sk_addr is 0 when idle)
//   sk_ready           sketch accepts the offered address
//   sk_query_en        one-cycle query/flush strobe to the sketch
//   fifo_level         occupied buffer entries
//   epoch_cnt          completed queries, wraps modulo 2^16
//   busy               FSM not idle or buffer not empty
module cm_sketch_feeder #(
  parameter int ADDR_SIZE  = 22,
  parameter int FIFO_DEPTH = 8,
  parameter int EPOCH_LEN  = 1024,
  parameter int FLUSH_WAIT = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [ADDR_SIZE-1:0]        in_addr,
  output logic                        in_ready,
  input  logic                        force_query,
  output logic                        sk_valid,
  output logic [ADDR_SIZE-1:0]        sk_addr,
  input  logic                        sk_ready,
  output logic                        sk_query_en,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 epoch_cnt,
  output logic                        busy
);

  localparam int IDX_W  = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int CNT_W  = $clog2(EPOCH_LEN + 1);
  localparam int WCNT_W = $clog2(FLUSH_WAIT + 1);

  localparam logic [PTR_W-1:0]  FULL_LEVEL = PTR_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  EPOCH_MAX  = CNT_W'(EPOCH_LEN);
  localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(FLUSH_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_QUERY = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    sent_cnt_q, sent_cnt_d;
  logic                query_pending_q, query_pending_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [15:0]         epoch_cnt_q, epoch_cnt_d;

  logic [ADDR_SIZE-1:0] mem [FIFO_DEPTH];

  logic push;
  logic pop;
  logic fifo_empty;

  // Pointers carry one wrap bit, so their difference is the true occupancy
  // and full/empty are distinguishable without a separate counter.
  assign fifo_level  = wr_ptr_q - rd_ptr_q;
  assign in_ready    = (fifo_level != FULL_LEVEL);
  assign fifo_empty  = (fifo_level == '0);
  assign sk_valid    = (state_q == S_SEND);
  assign sk_addr     = sk_valid ? mem[rd_ptr_q[IDX_W-1:0]] : '0;
  assign sk_query_en = (state_q == S_QUERY);
  assign epoch_cnt   = epoch_cnt_q;
  assign busy        = (state_q != S_IDLE) || !fifo_empty;
  assign push        = in_valid && in_ready;
  assign pop         = sk_valid && sk_ready;

  always_comb begin
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    state_d         = state_q;
    sent_cnt_d      = sent_cnt_q;
    query_pending_d = query_pending_q;
    wait_cnt_d      = wait_cnt_q;
    epoch_cnt_d     = epoch_cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    // An early query request only registers while an epoch is running; the
    // flush sequence itself ignores it.
    if (force_query && (state_q == S_IDLE || state_q == S_SEND))
      query_pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        // A pending query wins over buffered data. Clearing here also
        // swallows a force_query in this same cycle, so one query results.
        if (query_pending_q) begin
          state_d         = S_QUERY;
          sent_cnt_d      = '0;
          query_pending_d = 1'b0;
        end else if (!fifo_empty) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        // Returning to IDLE after every acceptance guarantees a low cycle
        // on sk_valid between transfers.
        if (sk_ready) begin
          state_d = S_IDLE;
          if (sent_cnt_q != EPOCH_MAX) begin
            sent_cnt_d = sent_cnt_q + CNT_W'(1);
            if (sent_cnt_q + CNT_W'(1) == EPOCH_MAX) query_pending_d = 1'b1;
          end
        end
      end
      S_QUERY: begin
        state_d    = S_WAIT;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d     = S_IDLE;
          epoch_cnt_d = epoch_cnt_q + 16'd1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      sent_cnt_q      <= '0;
      query_pending_q <= 1'b0;
      wait_cnt_q      <= '0;
      epoch_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      sent_cnt_q      <= sent_cnt_d;
      query_pending_q <= query_pending_d;
      wait_cnt_q      <= wait_cnt_d;
      epoch_cnt_q     <= epoch_cnt_d;
    end
  end

  // Storage is not reset: resetting the pointers already discards contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[IDX_W-1:0]] <= in_addr;
  end

endmodule

// File: tb/tb_cm_sketch_feeder.sv
// Testbench for cm_sketch_feeder: scenario tasks plus a transaction-level
// scoreboard (queue of pushed addresses, observed transfers, query counts).
module tb_cm_sketch_feeder;

  localparam int ADDR_SIZE  = 22;
  localparam int FIFO_DEPTH = 8;
  localparam int EPOCH_LEN  = 4;
  localparam int FLUSH_WAIT = 6;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        in_valid;
  logic [ADDR_SIZE-1:0]        in_addr;
  logic                        in_ready;
  logic                        force_query;
  logic                        sk_valid;
  logic [ADDR_SIZE-1:0]        sk_addr;
  logic                        sk_ready;
  logic                        sk_query_en;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;
  logic [15:0]                 epoch_cnt;
  logic                        busy;

  cm_sketch_feeder #(
    .ADDR_SIZE (ADDR_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH),
    .EPOCH_LEN (EPOCH_LEN),
    .FLUSH_WAIT(FLUSH_WAIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_addr    (in_addr),
    .in_ready   (in_ready),
    .force_query(force_query),
    .sk_valid   (sk_valid),
    .sk_addr    (sk_addr),
    .sk_ready   (sk_ready),
    .sk_query_en(sk_query_en),
    .fifo_level (fifo_level),
    .epoch_cnt  (epoch_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard state
  logic [ADDR_SIZE-1:0] model_q[$];
  logic [ADDR_SIZE-1:0] got_q[$];
  int                   got_cyc[$];
  int cyc, mdl_level, qcnt, acc_since_q, last_q_cyc, first_valid_cyc;
  int rule_err, lvl_err;
  bit allow_force, last_push, last_pop, prev_hold, prev_pop, prev_q;
  logic [ADDR_SIZE-1:0] prev_addr;

  task automatic clear_model();
    model_q.delete(); got_q.delete(); got_cyc.delete();
    mdl_level = 0; qcnt = 0; acc_since_q = 0; last_q_cyc = -1000;
    first_valid_cyc = -1; rule_err = 0; lvl_err = 0; allow_force = 0;
    prev_hold = 0; prev_pop = 0; prev_q = 0; prev_addr = '0;
    last_push = 0; last_pop = 0;
  endtask

  // One clock cycle: sample at negedge, update scoreboard, return at posedge+1.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (fifo_level !== mdl_level[$clog2(FIFO_DEPTH):0]) lvl_err++;
    last_push = in_valid && in_ready;
    last_pop  = sk_valid && sk_ready;
    if (!sk_valid && sk_addr !== '0) rule_err++;
    if (sk_valid && sk_query_en) rule_err++;
    if (prev_hold && (!sk_valid || sk_addr !== prev_addr)) rule_err++;
    if (sk_valid && prev_pop) rule_err++;
    if (sk_valid && (cyc - last_q_cyc) < FLUSH_WAIT + 2) rule_err++;
    if (sk_query_en) begin
      if (prev_q) rule_err++;
      if (!allow_force && acc_since_q != EPOCH_LEN) rule_err++;
      acc_since_q = 0; last_q_cyc = cyc; qcnt++;
    end
    if (last_push) begin model_q.push_back(in_addr); mdl_level++; end
    if (last_pop) begin
      got_q.push_back(sk_addr); got_cyc.push_back(cyc);
      acc_since_q++; mdl_level--;
    end
    if (sk_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    prev_hold = sk_valid && !sk_ready; prev_addr = sk_addr;
    prev_pop = last_pop; prev_q = sk_query_en;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_addr = '0; force_query = 0; sk_ready = 0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    clear_model();
  endtask

  task automatic push_one(input logic [ADDR_SIZE-1:0] a);
    bit done = 0;
    in_valid = 1; in_addr = a;
    for (int i = 0; i < 50 && !done; i++) begin
      step();
      done = last_push;
    end
    in_valid = 0;
    n_checks++;
    if (!done) begin n_errors++; $display("FAIL push_timeout: addr %h not accepted in 50 cycles", a); end
  endtask

  task automatic wait_valid();
    bit seen = sk_valid;
    for (int i = 0; i < 20 && !seen; i++) begin step(); seen = sk_valid; end
    n_checks++;
    if (!seen) begin n_errors++; $display("FAIL wait_valid: sk_valid never rose within 20 cycles"); end
  endtask

  task automatic check_order(input string name);
    bit ok = (got_q.size() == model_q.size());
    if (ok) foreach (got_q[i]) if (got_q[i] !== model_q[i]) ok = 0;
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d addrs (first %h), expected %0d addrs (first %h)", name,
               got_q.size(), (got_q.size() > 0) ? got_q[0] : '0,
               model_q.size(), (model_q.size() > 0) ? model_q[0] : '0);
    end
  endtask

  task automatic check_rules(input string name);
    n_checks++;
    if (rule_err !== 0 || lvl_err !== 0) begin
      n_errors++;
      $display("FAIL %s_rules: protocol errors %0d, level errors %0d, required 0 and 0", name, rule_err, lvl_err);
    end
  endtask

  task automatic test_reset();
    in_valid = 0; in_addr = '0; force_query = 0; sk_ready = 0;
    rst_n = 0; #3;
    n_checks++;
    if (in_ready !== 1'b1 || sk_valid !== 1'b0 || sk_addr !== '0 || sk_query_en !== 1'b0) begin
      n_errors++; $display("FAIL reset_hs: in_ready=%b sk_valid=%b sk_addr=%h sk_query_en=%b, required 1 0 0 0",
                           in_ready, sk_valid, sk_addr, sk_query_en);
    end
    n_checks++;
    if (fifo_level !== '0 || busy !== 1'b0 || epoch_cnt !== 16'd0) begin
      n_errors++; $display("FAIL reset_status: fifo_level=%0d busy=%b epoch_cnt=%0d, required 0 0 0",
                           fifo_level, busy, epoch_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1;
    clear_model();
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (sk_valid !== 1'b0 || busy !== 1'b0 || fifo_level !== '0) begin
      n_errors++; $display("FAIL reset_idle: sk_valid=%b busy=%b level=%0d, required 0 0 0", sk_valid, busy, fifo_level);
    end
  endtask

  task automatic test_single();
    int pc;
    do_reset();
    sk_ready = 1;
    push_one(22'h00ABC);
    pc = cyc;
    n_checks++;
    if (fifo_level !== 1) begin n_errors++; $display("FAIL single_level: fifo_level=%0d, required 1", fifo_level); end
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 22'h00ABC) begin
      n_errors++; $display("FAIL single_addr: got %0d transfers first %h, required 1 of 00abc",
                           got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
    end
    n_checks++;
    if (first_valid_cyc != pc + 2) begin
      n_errors++; $display("FAIL single_latency: sk_valid at cycle %0d, required %0d", first_valid_cyc, pc + 2);
    end
    n_checks++;
    if (qcnt != 0 || fifo_level !== 0) begin
      n_errors++; $display("FAIL single_end: queries %0d level %0d, required 0 0", qcnt, fifo_level);
    end
    check_rules("single");
  endtask

  task automatic test_backpressure();
    logic [ADDR_SIZE-1:0] list[9];
    int i = 0;
    do_reset();
    foreach (list[k]) list[k] = ADDR_SIZE'($urandom);
    in_valid = 1;
    for (int c = 0; c < 40 && i < 8; c++) begin
      in_addr = list[i]; step(); if (last_push) i++;
    end
    n_checks++;
    if (in_ready !== 1'b0 || fifo_level !== 8) begin
      n_errors++; $display("FAIL bp_full: in_ready=%b level=%0d, required 0 8", in_ready, fifo_level);
    end
    in_addr = list[8];
    for (int c = 0; c < 3; c++) begin step(); if (last_push) i++; end
    n_checks++;
    if (i != 8 || in_ready !== 1'b0) begin
      n_errors++; $display("FAIL bp_hold: pushes %0d in_ready=%b, required 8 0", i, in_ready);
    end
    sk_ready = 1;
    for (int c = 0; c < 40 && i < 9; c++) begin step(); if (last_push) i++; end
    in_valid = 0;
    for (int c = 0; c < 80 && got_q.size() < 9; c++) step();
    n_checks++;
    if (got_q.size() != 9) begin n_errors++; $display("FAIL bp_count: got %0d transfers, required 9", got_q.size()); end
    check_order("bp_order");
    check_rules("bp");
  endtask

  task automatic test_epoch();
    do_reset();
    sk_ready = 1;
    for (int k = 0; k < 6; k++) push_one(ADDR_SIZE'(32'h100 + k));
    for (int k = 0; k < 40; k++) step();
    check_order("epoch_order");
    n_checks++;
    if (qcnt != 1 || epoch_cnt !== 16'd1) begin
      n_errors++; $display("FAIL epoch_count: queries %0d epoch_cnt %0d, required 1 1", qcnt, epoch_cnt);
    end
    if (got_cyc.size() == 6) begin
      n_checks++;
      if (last_q_cyc != got_cyc[3] + 2) begin
        n_errors++; $display("FAIL epoch_qtime: query at %0d, required %0d", last_q_cyc, got_cyc[3] + 2);
      end
      n_checks++;
      if (got_cyc[4] != got_cyc[3] + FLUSH_WAIT + 4) begin
        n_errors++; $display("FAIL epoch_resume: 5th accept at %0d, required %0d", got_cyc[4], got_cyc[3] + FLUSH_WAIT + 4);
      end
    end else begin
      n_checks++; n_errors++;
      $display("FAIL epoch_xfers: got %0d transfers, required 6", got_cyc.size());
    end
    check_rules("epoch");
  endtask

  task automatic test_force();
    do_reset();
    allow_force = 1;
    push_one(22'h2F00D);
    wait_valid();
    force_query = 1; step(); force_query = 0;
    step(); step();
    sk_ready = 1;
    for (int k = 0; k < 20 && qcnt == 0; k++) step();
    force_query = 1; step(); force_query = 0;
    for (int k = 0; k < 20; k++) step();
    check_order("force_order");
    n_checks++;
    if (got_cyc.size() != 1 || got_cyc[0] >= last_q_cyc) begin
      n_errors++; $display("FAIL force_seq: %0d transfers, query at %0d, required 1 transfer before query",
                           got_cyc.size(), last_q_cyc);
    end
    n_checks++;
    if (qcnt != 1 || epoch_cnt !== 16'd1) begin
      n_errors++; $display("FAIL force_count: queries %0d epoch_cnt %0d, required 1 1", qcnt, epoch_cnt);
    end
    check_rules("force");
    allow_force = 0;
  endtask

  task automatic test_wrap();
    int pushed = 0;
    do_reset();
    for (int k = 0; k < 3; k++) push_one(ADDR_SIZE'($urandom));
    wait_valid();
    in_valid = 1; in_addr = ADDR_SIZE'($urandom); sk_ready = 1;
    step();
    in_valid = 0;
    n_checks++;
    if (!(last_push && last_pop) || fifo_level !== 3) begin
      n_errors++; $display("FAIL wrap_simul: push=%b pop=%b level=%0d, required 1 1 3", last_push, last_pop, fifo_level);
    end
    for (int c = 0; c < 300 && pushed < 20; c++) begin
      in_valid = $urandom_range(0, 1); in_addr = ADDR_SIZE'($urandom);
      step(); if (last_push) pushed++;
    end
    in_valid = 0;
    for (int c = 0; c < 200 && got_q.size() < model_q.size(); c++) step();
    n_checks++;
    if (got_q.size() != 24) begin n_errors++; $display("FAIL wrap_count: got %0d transfers, required 24", got_q.size()); end
    check_order("wrap_order");
    check_rules("wrap");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) push_one(ADDR_SIZE'(32'h3000 + k));
    wait_valid();
    #2; rst_n = 0; #1;
    n_checks++;
    if (sk_valid !== 1'b0 || sk_addr !== '0 || sk_query_en !== 1'b0 || in_ready !== 1'b1) begin
      n_errors++; $display("FAIL rstmid_hs: sk_valid=%b sk_addr=%h sk_query_en=%b in_ready=%b, required 0 0 0 1",
                           sk_valid, sk_addr, sk_query_en, in_ready);
    end
    n_checks++;
    if (fifo_level !== '0 || busy !== 1'b0 || epoch_cnt !== 16'd0) begin
      n_errors++; $display("FAIL rstmid_status: level=%0d busy=%b epoch=%0d, required 0 0 0", fifo_level, busy, epoch_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1;
    clear_model();
    sk_ready = 1;
    for (int k = 0; k < 15; k++) step();
    n_checks++;
    if (got_q.size() != 0 || first_valid_cyc >= 0) begin
      n_errors++; $display("FAIL rstmid_stale: %0d transfers after reset, required 0", got_q.size());
    end
    check_rules("rstmid");
  endtask

  task automatic test_random();
    int exp_q;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      in_valid = $urandom_range(0, 1);
      in_addr  = ADDR_SIZE'($urandom);
      sk_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    in_valid = 0; sk_ready = 1;
    for (int c = 0; c < 300; c++) step();
    exp_q = got_q.size() / EPOCH_LEN;
    n_checks++;
    if (model_q.size() == 0) begin n_errors++; $display("FAIL rand_stim: 0 pushes, required >0"); end
    check_order("rand_order");
    n_checks++;
    if (qcnt != exp_q || epoch_cnt !== 16'(exp_q)) begin
      n_errors++; $display("FAIL rand_epochs: queries %0d epoch_cnt %0d, required %0d", qcnt, epoch_cnt, exp_q);
    end
    check_rules("rand");
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish within 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc = 0;
    clear_model();
    test_reset();
    test_single();
    test_backpressure();
    test_epoch();
    test_force();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
